// File: rtl/tmds_decoder_rx.sv
// tmds_decoder_rx: single-lane TMDS receiver.
// Deserialises one bit per clk (bit0 of each word first) and finds the 10-bit word
// boundary by bit-slipping until DVI control tokens line up. Each aligned word is
// decoded to video data (vde=1) or control data (vde=0).
//
// Ports:
//   clk          bit clock (10x pixel clock)
//   reset        asynchronous, active-high
//   tmds_in      serial TMDS bit, already in the clk domain
//   word_strobe  1-clk pulse: word_out/vd/cd/vde/locked updated this cycle
//   word_out     raw 10-bit word at the current alignment
//   vd           decoded video data (0 unless locked data word)
//   cd           decoded control data {c1,c0} (0 unless locked control word)
//   vde          1 = data word, 0 = control word or unlocked
//   locked       word alignment established
module tmds_decoder_rx #(
    parameter int unsigned lock_tokens  = 16,
    parameter int unsigned search_words = 1024,
    parameter int unsigned slip_guard   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tmds_in,
    output logic       word_strobe,
    output logic [9:0] word_out,
    output logic [7:0] vd,
    output logic [1:0] cd,
    output logic       vde,
    output logic       locked
);

    localparam int unsigned TokW   = $clog2(lock_tokens + 1);
    localparam int unsigned MissW  = $clog2(search_words + 1);
    localparam int unsigned GuardW = (slip_guard > 0) ? $clog2(slip_guard + 1) : 1;

    typedef enum logic [1:0] {StSearch, StSlip, StLocked} state_e;

    // Deserializer
    logic [9:0] sh_q;
    logic [3:0] phase_q, phase_d;
    logic [9:0] word_q;
    logic       cap_q;
    logic       slip_req;

    // FSM
    state_e            state_q, state_d;
    logic [TokW-1:0]   tok_cnt_q, tok_cnt_d;
    logic [MissW-1:0]  miss_cnt_q, miss_cnt_d;
    logic [GuardW-1:0] guard_cnt_q, guard_cnt_d;
    logic              word_locked;

    // Decode
    logic       is_tok;
    logic [1:0] tok_cd;
    logic [7:0] dat_d;
    logic [7:0] dat_vd;

    // Output registers
    logic       strobe_q;
    logic [9:0] word_out_q;
    logic [7:0] vd_q;
    logic [1:0] cd_q;
    logic       vde_q;
    logic       locked_q;

    // A slip is only requested on the cycle after a capture, when phase is 0; holding
    // the phase there stretches the current frame to 11 clks.
    always_comb begin
        if (slip_req) begin
            phase_d = phase_q;
        end else if (phase_q == 4'd9) begin
            phase_d = 4'd0;
        end else begin
            phase_d = phase_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q    <= '0;
            phase_q <= '0;
            word_q  <= '0;
            cap_q   <= 1'b0;
        end else begin
            sh_q    <= {tmds_in, sh_q[9:1]};
            phase_q <= phase_d;
            cap_q   <= (phase_q == 4'd9);
            if (phase_q == 4'd9) begin
                word_q <= {tmds_in, sh_q[9:1]};
            end
        end
    end

    always_comb begin
        is_tok = 1'b1;
        tok_cd = 2'b00;
        case (word_q)
            10'b1101010100: tok_cd = 2'b00;
            10'b0010101011: tok_cd = 2'b01;
            10'b0101010100: tok_cd = 2'b10;
            10'b1010101011: tok_cd = 2'b11;
            default:        is_tok = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        dat_d     = word_q[9] ? ~word_q[7:0] : word_q[7:0];
        dat_vd    = '0;
        dat_vd[0] = dat_d[0];
        for (int i = 1; i < 8; i++) begin
            dat_vd[i] = word_q[8] ? (dat_d[i] ^ dat_d[i-1]) : ~(dat_d[i] ^ dat_d[i-1]);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StSearch;
            tok_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            guard_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tok_cnt_q   <= tok_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            guard_cnt_q <= guard_cnt_d;
        end
    end

    // FSM next state, evaluated once per captured word
    always_comb begin
        state_d     = state_q;
        tok_cnt_d   = tok_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        guard_cnt_d = guard_cnt_q;
        slip_req    = 1'b0;
        if (cap_q) begin
            unique case (state_q)
                StSearch: begin
                    if (is_tok) begin
                        miss_cnt_d = '0;
                        if (tok_cnt_q == TokW'(lock_tokens - 1)) begin
                            tok_cnt_d = '0;
                            state_d   = StLocked;
                        end else begin
                            tok_cnt_d = tok_cnt_q + TokW'(1);
                        end
                    end else begin
                        tok_cnt_d = '0;
                        if (miss_cnt_q == MissW'(search_words - 1)) begin
                            miss_cnt_d = '0;
                            slip_req   = 1'b1;
                            state_d    = StSlip;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MissW'(1);
                        end
                    end
                end
                StSlip: begin
                    // Words straddling the old boundary are still in flight; skip them.
                    if (32'(guard_cnt_q) + 32'd1 >= slip_guard) begin
                        guard_cnt_d = '0;
                        state_d     = StSearch;
                    end else begin
                        guard_cnt_d = guard_cnt_q + GuardW'(1);
                    end
                end
                StLocked: begin
                    if (is_tok) begin
                        miss_cnt_d = '0;
                    end else if (miss_cnt_q == MissW'(search_words - 1)) begin
                        miss_cnt_d = '0;
                        slip_req   = 1'b1;
                        state_d    = StSlip;
                    end else begin
                        miss_cnt_d = miss_cnt_q + MissW'(1);
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    // FSM output: lock rises one word after entry, but falls on the word that exhausts
    // the miss budget.
    always_comb begin
        word_locked = (state_q == StLocked) && !slip_req;
    end

    // One-word output pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_q   <= 1'b0;
            word_out_q <= '0;
            vd_q       <= '0;
            cd_q       <= '0;
            vde_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            strobe_q <= cap_q;
            if (cap_q) begin
                word_out_q <= word_q;
                locked_q   <= word_locked;
                if (!word_locked) begin
                    vde_q <= 1'b0;
                    vd_q  <= '0;
                    cd_q  <= '0;
                end else if (is_tok) begin
                    vde_q <= 1'b0;
                    vd_q  <= '0;
                    cd_q  <= tok_cd;
                end else begin
                    vde_q <= 1'b1;
                    vd_q  <= dat_vd;
                    cd_q  <= '0;
                end
            end
        end
    end

    assign word_strobe = strobe_q;
    assign word_out    = word_out_q;
    assign vd          = vd_q;
    assign cd          = cd_q;
    assign vde         = vde_q;
    assign locked      = locked_q;

endmodule
